// File: rtl/mc_ctrl_pkg.sv
// Shared types and codes for the multicycle MIPS controller.
// Optional macro EXT_INSTR_EN adds the addi/j/bne states to the state enum.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8
`ifdef EXT_INSTR_EN
    ,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
`endif
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// Combinational ALU decoder: (aluop, funct) -> alucontrol, plus a flag for
// funct codes the R-type path cannot execute (independent of aluop).
module mc_aludec
  import mc_ctrl_pkg::*;
(
  input  aluop_e     aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       funct_bad_o
);

  logic [2:0] functCtrl;

  always_comb begin
    functCtrl   = ALU_AND;
    funct_bad_o = 1'b0;
    case (funct_i)
      FN_ADD:  functCtrl = ALU_ADD;
      FN_SUB:  functCtrl = ALU_SUB;
      FN_AND:  functCtrl = ALU_AND;
      FN_OR:   functCtrl = ALU_OR;
      FN_SLT:  functCtrl = ALU_SLT;
      default: funct_bad_o = 1'b1;
    endcase
  end

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD:   alucontrol_o = ALU_ADD;
      ALUOP_SUB:   alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: alucontrol_o = functCtrl;
      default:     alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller_p.sv
// Parametrised multicycle MIPS controller with memory wait states.
// Define EXT_INSTR_EN to compile in the addi, j and bne instructions.
module mc_controller_p
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 0,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;
  logic             functBad;
  logic             opIllegal;
  aluop_e           aluop;
  logic             aluEn;
  logic [2:0]       aluDec;
  logic             pcwrite, branch, branchNe;

  mc_aludec u_aludec (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (aluDec),
    .funct_bad_o  (functBad)
  );

  assign last       = (cnt_q == LAT);
  assign state_dbg  = state_q;
  assign alucontrol = aluEn ? aluDec : 3'b000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    opIllegal = 1'b1;
    case (op)
      OP_LW, OP_SW, OP_BEQ: opIllegal = 1'b0;
      OP_RTYPE:             opIllegal = functBad;
`ifdef EXT_INSTR_EN
      OP_ADDI, OP_J, OP_BNE: opIllegal = 1'b0;
`endif
      default:              opIllegal = 1'b1;
    endcase
  end

  // Memory states hold until the counter reaches MEM_LAT; the counter is zero elsewhere.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (is_mem_state(state_q) && !last) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          state_d = S_FETCH;
          if (!opIllegal) begin
            case (op)
              OP_LW, OP_SW: state_d = S_MEMADR;
              OP_RTYPE:     state_d = S_RTYPEEX;
              OP_BEQ:       state_d = S_BEQEX;
`ifdef EXT_INSTR_EN
              OP_ADDI:      state_d = S_ADDIEX;
              OP_J:         state_d = S_JEX;
              OP_BNE:       state_d = S_BNEEX;
`endif
              default:      state_d = S_FETCH;
            endcase
          end
        end
        S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD :
                            (op == OP_SW) ? S_MEMWR : S_FETCH;
        S_MEMRD:   state_d = S_MEMWB;
        S_RTYPEEX: state_d = S_RTYPEWB;
`ifdef EXT_INSTR_EN
        S_ADDIEX:  state_d = S_ADDIWB;
`endif
        default:   state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    aluop = ALUOP_ADD;
    aluEn = 1'b0;
    case (state_q)
      S_FETCH, S_DECODE, S_MEMADR: aluEn = 1'b1;
      S_RTYPEEX: begin aluEn = 1'b1; aluop = ALUOP_FUNCT; end
      S_BEQEX:   begin aluEn = 1'b1; aluop = ALUOP_SUB; end
`ifdef EXT_INSTR_EN
      S_ADDIEX:  aluEn = 1'b1;
      S_BNEEX:   begin aluEn = 1'b1; aluop = ALUOP_SUB; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    branchNe = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH:   begin alusrcb = 2'b01; irwrite = last; pcwrite = last; end
      S_DECODE:  begin alusrcb = 2'b11; illegal = opIllegal; end
      S_MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB:   begin regwrite = 1'b1; memtoreg = 1'b1; end
      S_MEMWR:   begin iord = 1'b1; memwrite = last; end
      S_RTYPEEX: alusrca = 1'b1;
      S_RTYPEWB: begin regwrite = 1'b1; regdst = 1'b1; end
      S_BEQEX:   begin alusrca = 1'b1; pcsrc = 2'b01; branch = 1'b1; end
`ifdef EXT_INSTR_EN
      S_ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      S_ADDIWB:  regwrite = 1'b1;
      S_JEX:     begin pcsrc = 2'b10; pcwrite = 1'b1; end
      S_BNEEX:   begin alusrca = 1'b1; pcsrc = 2'b01; branchNe = 1'b1; end
`endif
      default: ;
    endcase
    pcen = pcwrite | (branch & zero) | (branchNe & ~zero);
    // Strobes must stay quiet for the whole time reset is held low.
    if (!reset) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller_p.sv
// Scoreboard bench for mc_controller_p at MEM_LAT 0, 2 and 3.
// Expectations for addi/j/bne follow EXT_INSTR_EN.
module tb_mc_controller_p;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluc;
  } out_t;

  typedef struct {
    string          name;
    logic [5:0]     op;
    logic [5:0]     funct;
    logic           zero;
    int             n;
    logic [3:0][3:0] path;
    logic [2:0]     alu;
    logic           ill;
  } vec_t;

  typedef struct {
    out_t  exp;
    string tag;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstW [3];
  logic [5:0] op, funct;
  logic       zero;
  logic       pcenW [3], memwriteW [3], irwriteW [3], regwriteW [3], alusrcaW [3];
  logic       iordW [3], memtoregW [3], regdstW [3], illegalW [3];
  logic [1:0] alusrcbW [3], pcsrcW [3];
  logic [2:0] alucW [3];
  logic [3:0] stW [3];

  sb_t  sbq[$];
  vec_t vecs [15];
  int   checks = 0;
  int   failures = 0;

  for (genvar g = 0; g < 3; g++) begin : gDut
    mc_controller_p #(.MEM_LAT((g == 0) ? 0 : g + 1), .CNT_W(4)) dut (
      .clk        (clk),
      .reset      (rstW[g]),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .pcen       (pcenW[g]),
      .memwrite   (memwriteW[g]),
      .irwrite    (irwriteW[g]),
      .regwrite   (regwriteW[g]),
      .alusrca    (alusrcaW[g]),
      .iord       (iordW[g]),
      .memtoreg   (memtoregW[g]),
      .regdst     (regdstW[g]),
      .alusrcb    (alusrcbW[g]),
      .pcsrc      (pcsrcW[g]),
      .alucontrol (alucW[g]),
      .illegal    (illegalW[g]),
      .state_dbg  (stW[g])
    );
  end

  function automatic int latOf(input int d);
    return (d == 0) ? 0 : d + 1;
  endfunction

  function automatic vec_t mk(input string name, input logic [5:0] o, input logic [5:0] f,
                              input logic z, input int n, input logic [15:0] p,
                              input logic [2:0] alu, input logic ill);
    vec_t v;
    v.name = name; v.op = o; v.funct = f; v.zero = z;
    v.n = n; v.path = p; v.alu = alu; v.ill = ill;
    return v;
  endfunction

  // Expected outputs per state, written from the controller's state table.
  function automatic out_t expOut(input logic [3:0] st, input logic last, input logic z,
                                  input logic [2:0] alu, input logic ill);
    out_t o = '0;
    o.st = st;
    case (st)
      4'd0:  begin o.alusrcb = 2'b01; o.aluc = 3'b010; o.irwrite = last; o.pcen = last; end
      4'd1:  begin o.alusrcb = 2'b11; o.aluc = 3'b010; o.illegal = ill; end
      4'd2:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluc = 3'b010; end
      4'd3:  o.iord = 1'b1;
      4'd4:  begin o.regwrite = 1'b1; o.memtoreg = 1'b1; end
      4'd5:  begin o.iord = 1'b1; o.memwrite = last; end
      4'd6:  begin o.alusrca = 1'b1; o.aluc = alu; end
      4'd7:  begin o.regwrite = 1'b1; o.regdst = 1'b1; end
      4'd8:  begin o.alusrca = 1'b1; o.aluc = 3'b110; o.pcsrc = 2'b01; o.pcen = z; end
      4'd9:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluc = 3'b010; end
      4'd10: o.regwrite = 1'b1;
      4'd11: begin o.pcsrc = 2'b10; o.pcen = 1'b1; end
      4'd12: begin o.alusrca = 1'b1; o.aluc = 3'b110; o.pcsrc = 2'b01; o.pcen = ~z; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic out_t getAct(input int d);
    out_t a;
    a.st = stW[d]; a.pcen = pcenW[d]; a.memwrite = memwriteW[d]; a.irwrite = irwriteW[d];
    a.regwrite = regwriteW[d]; a.alusrca = alusrcaW[d]; a.iord = iordW[d];
    a.memtoreg = memtoregW[d]; a.regdst = regdstW[d]; a.illegal = illegalW[d];
    a.alusrcb = alusrcbW[d]; a.pcsrc = pcsrcW[d]; a.aluc = alucW[d];
    return a;
  endfunction

  task automatic pushExp(input out_t o, input string tag);
    sb_t e;
    e.exp = o;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic pushFetch(input int lat, input string name);
    for (int k = 0; k <= lat; k++)
      pushExp(expOut(4'd0, k == lat, 1'b0, 3'b000, 1'b0), $sformatf("%s fetch%0d", name, k));
  endtask

  task automatic applyStimulus(input int d, input vec_t v);
    int lat;
    int reps;
    logic [3:0] st;
    lat = latOf(d);
    op = v.op; funct = v.funct; zero = v.zero;
    pushFetch(lat, v.name);
    pushExp(expOut(4'd1, 1'b0, v.zero, v.alu, v.ill), $sformatf("%s decode", v.name));
    for (int i = 0; i < v.n; i++) begin
      st = v.path[i];
      reps = (st == 4'd3 || st == 4'd5) ? lat + 1 : 1;
      for (int k = 0; k < reps; k++)
        pushExp(expOut(st, k == reps - 1, v.zero, v.alu, v.ill),
                $sformatf("%s st%0d.%0d", v.name, st, k));
    end
  endtask

  task automatic checkOutput(input int d);
    sb_t  e;
    out_t a;
    e = sbq.pop_front();
    a = getAct(d);
    checks++;
    if (a !== e.exp) begin
      failures++;
      $display("[TB] FAIL dut%0d %s: got st=%0d bits=%h, expected st=%0d bits=%h",
               d, e.tag, a.st, a, e.exp.st, e.exp);
    end
  endtask

  // Samples one expected record per falling edge, then parks just after a rising edge.
  task automatic drain(input int d);
    while (sbq.size() > 0) begin
      @(negedge clk);
      checkOutput(d);
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = mk("lw",    6'b100011, 6'b000000, 1'b0, 3, 16'h0432, 3'b000, 1'b0);
    vecs[1]  = mk("sw",    6'b101011, 6'b000000, 1'b0, 2, 16'h0052, 3'b000, 1'b0);
    vecs[2]  = mk("add",   6'b000000, 6'b100000, 1'b0, 2, 16'h0076, 3'b010, 1'b0);
    vecs[3]  = mk("sub",   6'b000000, 6'b100010, 1'b1, 2, 16'h0076, 3'b110, 1'b0);
    vecs[4]  = mk("and",   6'b000000, 6'b100100, 1'b0, 2, 16'h0076, 3'b000, 1'b0);
    vecs[5]  = mk("or",    6'b000000, 6'b100101, 1'b0, 2, 16'h0076, 3'b001, 1'b0);
    vecs[6]  = mk("slt",   6'b000000, 6'b101010, 1'b0, 2, 16'h0076, 3'b111, 1'b0);
    vecs[7]  = mk("rbad",  6'b000000, 6'b111111, 1'b0, 0, 16'h0000, 3'b000, 1'b1);
    vecs[8]  = mk("beqz1", 6'b000100, 6'b000000, 1'b1, 1, 16'h0008, 3'b000, 1'b0);
    vecs[9]  = mk("beqz0", 6'b000100, 6'b000000, 1'b0, 1, 16'h0008, 3'b000, 1'b0);
    vecs[10] = mk("badop", 6'b111111, 6'b000000, 1'b0, 0, 16'h0000, 3'b000, 1'b1);
`ifdef EXT_INSTR_EN
    vecs[11] = mk("addi",  6'b001000, 6'b000000, 1'b0, 2, 16'h00A9, 3'b000, 1'b0);
    vecs[12] = mk("j",     6'b000010, 6'b000000, 1'b0, 1, 16'h000B, 3'b000, 1'b0);
    vecs[13] = mk("bnez0", 6'b000101, 6'b000000, 1'b0, 1, 16'h000C, 3'b000, 1'b0);
    vecs[14] = mk("bnez1", 6'b000101, 6'b000000, 1'b1, 1, 16'h000C, 3'b000, 1'b0);
`else
    vecs[11] = mk("addi",  6'b001000, 6'b000000, 1'b0, 0, 16'h0000, 3'b000, 1'b1);
    vecs[12] = mk("j",     6'b000010, 6'b000000, 1'b0, 0, 16'h0000, 3'b000, 1'b1);
    vecs[13] = mk("bnez0", 6'b000101, 6'b000000, 1'b0, 0, 16'h0000, 3'b000, 1'b1);
    vecs[14] = mk("bnez1", 6'b000101, 6'b000000, 1'b1, 0, 16'h0000, 3'b000, 1'b1);
`endif

    for (int d = 0; d < 3; d++) rstW[d] = 1'b0;
    op = 6'b100011; funct = 6'b000000; zero = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // In reset: FETCH decode visible, strobes forced low even with MEM_LAT=0.
    pushExp(expOut(4'd0, 1'b0, 1'b0, 3'b000, 1'b0), "reset0");
    drain(0);
    pushExp(expOut(4'd0, 1'b0, 1'b0, 3'b000, 1'b0), "reset3");
    drain(2);

    rstW[0] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, vecs[i]);
      drain(0);
    end
    rstW[0] = 1'b0;

    rstW[1] = 1'b1;
    applyStimulus(1, vecs[0]);
    drain(1);
    applyStimulus(1, vecs[1]);
    drain(1);
    rstW[1] = 1'b0;

    // sw at MEM_LAT=3, reset hits in the second MEMWR cycle.
    rstW[2] = 1'b1;
    op = 6'b101011; funct = 6'b000000; zero = 1'b0;
    pushFetch(3, "swabort");
    pushExp(expOut(4'd1, 1'b0, 1'b0, 3'b000, 1'b0), "swabort decode");
    pushExp(expOut(4'd2, 1'b0, 1'b0, 3'b000, 1'b0), "swabort memadr");
    pushExp(expOut(4'd5, 1'b0, 1'b0, 3'b000, 1'b0), "swabort memwr0");
    drain(2);
    rstW[2] = 1'b0;
    for (int k = 0; k < 3; k++)
      pushExp(expOut(4'd0, 1'b0, 1'b0, 3'b000, 1'b0), $sformatf("abort hold%0d", k));
    drain(2);
    rstW[2] = 1'b1;
    pushFetch(3, "after_rst");
    pushExp(expOut(4'd1, 1'b0, 1'b0, 3'b000, 1'b0), "after_rst decode");
    drain(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
